tcam_rule_loader: RTL
=====================

Name: tcam_rule_loader

Overview:
Control-plane sequencer that drives the TCAM write port (wr_en / wr_is_mask / wr_addr / wr_data) from high-level rule commands issued by the processor.
- Accepts INSTALL, DELETE, CLEAR_ALL and READ commands over a valid/ready handshake.
- Orders the mask and value writes and tracks per-entry occupancy.
- Returns one response per command.
- Sits between the CSR/processor bridge and the TCAM lookup block.

Parameters:
KEY_W, 128, rule value/mask width; equals TCAM key width
ENTRIES, 16, number of TCAM entries
IDX_W, $clog2(ENTRIES), entry address width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  loader idle, command accepted on cmd_valid&&cmd_ready
cmd_op  in  2  0=INSTALL 1=DELETE 2=CLEAR_ALL 3=READ
cmd_addr  in  IDX_W  target entry (ignored for CLEAR_ALL)
cmd_value  in  KEY_W  rule value (INSTALL only)
cmd_mask  in  KEY_W  rule mask, 1=don't-care (INSTALL only)
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  command rejected
rsp_value  out  KEY_W  READ data: value
rsp_mask  out  KEY_W  READ data: mask
wr_en  out  1  TCAM write strobe
wr_is_mask  out  1  1=mask write, 0=value write
wr_addr  out  IDX_W  TCAM entry address
wr_data  out  KEY_W  TCAM write data
entry_valid  out  ENTRIES  bit k=1 while entry k holds an installed rule

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low; clock and reset ports are named clk and rst_n.
- All outputs are registered.
- Reset values:
  - cmd_ready=1.
  - rsp_valid, rsp_err, wr_en, wr_is_mask, wr_addr, wr_data, rsp_value, rsp_mask, entry_valid all 0.
- States: IDLE, WR_MASK, WR_VAL, RESP. cmd_ready=1 only in IDLE.
- On accept at edge t0, cmd_op/addr/value/mask are latched into staging registers. Later cmd_* changes are ignored.
- Address range check: cmd_addr>=ENTRIES applies only when ENTRIES is not a power of 2, and only for INSTALL/DELETE/READ. Such a command goes IDLE->RESP with rsp_err=1, no TCAM write and no entry_valid change.
- INSTALL:
  - WR_MASK cycle (t0..t1): wr_en=1, wr_is_mask=1, wr_data=mask.
  - WR_VAL cycle (t1..t2): wr_en=1, wr_is_mask=0, wr_data=value.
  - RESP cycle (t2..t3): rsp_valid=1, rsp_err=0, entry_valid[addr] set.
  - Back in IDLE at t3. Total 3 cycles accept-to-rsp_valid, 4 cycles to next cmd_ready.
- DELETE:
  - Same sequence with mask=all-ones and value=0 (TCAM reset pattern).
  - entry_valid[addr] cleared in RESP.
  - Deleting an entry that is not valid is legal: writes are still issued, rsp_err=0.
- CLEAR_ALL:
  - Entry counter k walks 0..ENTRIES-1. Each k gets a mask write (all-ones) then a value write (0): 2*ENTRIES consecutive wr_en cycles.
  - Then RESP with all entry_valid=0.
  - Counter wraps to 0 on exit.
- READ: IDLE->RESP with no TCAM writes. Data per optional feature below.
- wr_en is never high outside WR_MASK/WR_VAL. wr_addr and wr_data hold their last values when wr_en=0.
- rsp_value/rsp_mask are updated only by READ and hold otherwise.
- rsp has no back-pressure; the processor must sample on the rsp_valid strobe.
- Mask is always written before value for the same entry.
- Reset mid-operation drops the in-flight command:
  - wr_en falls to 0 asynchronously.
  - State returns to IDLE and entry_valid clears. This is consistent with the TCAM resetting to the same pattern.

Optional Feature:
SHADOW_READ_EN
- Defined:
  - Loader keeps a shadow value/mask array of ENTRIES x KEY_W each.
  - Shadow is reset to value=0, mask=all-ones and updated on every TCAM write it issues.
  - READ returns shadow[addr] on rsp_value/rsp_mask with rsp_err=0.
- Undefined:
  - No shadow storage.
  - READ responds in RESP with rsp_err=1, and rsp_value/rsp_mask are left unchanged.

Test Plan:
1. Reset, then INSTALL addr=3 value=0x...00AB mask=0x...FF00 -> cycle1 wr_en=1, wr_is_mask=1, wr_addr=3, wr_data=mask; cycle2 wr_is_mask=0, wr_data=value; cycle3 rsp_valid=1, rsp_err=0; entry_valid=16'h0008.
2. INSTALL addr=5, then DELETE addr=5 -> DELETE writes mask=all-ones then value=0 to addr 5; entry_valid bit5 returns to 0; rsp_err=0.
3. INSTALL entries 0, 7 and 15, then CLEAR_ALL -> exactly 32 consecutive wr_en cycles with addresses 0,0,1,1,...,15,15 and alternating wr_is_mask 1,0; then rsp_valid; entry_valid=0.
4. With SHADOW_READ_EN: INSTALL addr=9 value=V mask=M, then READ addr=9 -> rsp_value=V, rsp_mask=M, rsp_err=0. READ addr=2 (never written) -> value=0, mask=all-ones. Without the macro: rsp_err=1.
5. Hold cmd_valid high with a back-to-back command queue -> cmd_ready=0 during WR_MASK/WR_VAL/RESP. Exactly one accept per command; changing cmd_value after accept does not alter wr_data.
6. Assert rst_n=0 during the WR_VAL cycle of an INSTALL -> wr_en=0 immediately, no rsp_valid, entry_valid=0. After release, cmd_ready=1 and a new INSTALL completes normally.

Source files
------------

// File: rtl/tcam_rule_loader_if.sv
// Processor-side command/response bundle for the TCAM rule loader.
// The master is the CSR/processor bridge and the slave is the loader.
interface tcam_rule_loader_if #(
  parameter int KEY_W   = 128,
  parameter int ENTRIES = 16
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_addr;
  logic [KEY_W-1:0] cmd_value;
  logic [KEY_W-1:0] cmd_mask;

  // Responses have no back-pressure, so rsp_valid is a single-cycle strobe.
  logic             rsp_valid;
  logic             rsp_err;
  logic [KEY_W-1:0] rsp_value;
  logic [KEY_W-1:0] rsp_mask;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_value, cmd_mask,
    input  cmd_ready, rsp_valid, rsp_err, rsp_value, rsp_mask
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_value, cmd_mask,
    output cmd_ready, rsp_valid, rsp_err, rsp_value, rsp_mask
  );
endinterface

// File: rtl/tcam_rule_loader.sv
// Sequences INSTALL/DELETE/CLEAR_ALL/READ commands into ordered TCAM mask/value writes.
// Optional macro SHADOW_READ_EN adds a shadow array of value/mask words so that READ can return data.
module tcam_rule_loader #(
  parameter  int KEY_W   = 128,
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  tcam_rule_loader_if.slave   bus,
  output logic                wr_en,
  output logic                wr_is_mask,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [KEY_W-1:0]    wr_data,
  output logic [ENTRIES-1:0]  entry_valid
);

  typedef enum logic [1:0] {
    OP_INSTALL = 2'd0,
    OP_DELETE  = 2'd1,
    OP_CLEAR   = 2'd2,
    OP_READ    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_MASK = 2'd1,
    S_WR_VAL  = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  // A power-of-two depth makes every address legal, so the range check folds away.
  localparam bit               CHECK_RANGE = (ENTRIES & (ENTRIES - 1)) != 0;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ENTRIES - 1);
  localparam logic [KEY_W-1:0] ALL_ONES    = '1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [KEY_W-1:0] value_q, value_d;
  logic [KEY_W-1:0] mask_q, mask_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [KEY_W-1:0]   rsp_value_q, rsp_value_d;
  logic [KEY_W-1:0]   rsp_mask_q, rsp_mask_d;
  logic               wr_en_d, wr_is_mask_d;
  logic [IDX_W-1:0]   wr_addr_d;
  logic [KEY_W-1:0]   wr_data_d;
  logic [ENTRIES-1:0] entry_valid_d;
  logic               addr_bad;

`ifdef SHADOW_READ_EN
  logic [KEY_W-1:0] shadow_value [ENTRIES];
  logic [KEY_W-1:0] shadow_mask  [ENTRIES];

  // NOTE: the shadow must start at the TCAM reset pattern, so it is a resettable
  // register array rather than a RAM macro, which could not be cleared in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        shadow_value[k] <= '0;
        shadow_mask[k]  <= ALL_ONES;
      end
    end else if (wr_en) begin
      if (wr_is_mask) shadow_mask[wr_addr]  <= wr_data;
      else            shadow_value[wr_addr] <= wr_data;
    end
  end
`endif

  // The addr_q register doubles as the CLEAR_ALL entry counter.
  always_comb begin
    // NOTE: every signal assigned here gets its default first. Otherwise a path
    // through the case statement would leave it unassigned and infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    value_d       = value_q;
    mask_d        = mask_q;
    wr_en_d       = 1'b0;
    wr_is_mask_d  = wr_is_mask;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_value_d   = rsp_value_q;
    rsp_mask_d    = rsp_mask_q;
    entry_valid_d = entry_valid;
    addr_bad      = CHECK_RANGE && (32'(bus.cmd_addr) >= ENTRIES) &&
                    (op_e'(bus.cmd_op) != OP_CLEAR);

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          addr_d  = bus.cmd_addr;
          value_d = bus.cmd_value;
          mask_d  = bus.cmd_mask;
          if (addr_bad) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            unique case (op_e'(bus.cmd_op))
              OP_INSTALL, OP_DELETE, OP_CLEAR: begin
                // DELETE and CLEAR_ALL write the TCAM reset pattern.
                if (op_e'(bus.cmd_op) != OP_INSTALL) begin
                  value_d = '0;
                  mask_d  = ALL_ONES;
                end
                if (op_e'(bus.cmd_op) == OP_CLEAR) addr_d = '0;
                state_d      = S_WR_MASK;
                wr_en_d      = 1'b1;
                wr_is_mask_d = 1'b1;
                wr_addr_d    = addr_d;
                wr_data_d    = mask_d;
              end
              OP_READ: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
`ifdef SHADOW_READ_EN
                rsp_value_d = shadow_value[bus.cmd_addr];
                rsp_mask_d  = shadow_mask[bus.cmd_addr];
`else
                rsp_err_d   = 1'b1;
`endif
              end
            endcase
          end
        end
      end

      S_WR_MASK: begin
        state_d      = S_WR_VAL;
        wr_en_d      = 1'b1;
        wr_is_mask_d = 1'b0;
        wr_data_d    = value_q;
      end

      S_WR_VAL: begin
        if (op_q == OP_CLEAR && addr_q != LAST_IDX) begin
          addr_d       = addr_q + 1'b1;
          state_d      = S_WR_MASK;
          wr_en_d      = 1'b1;
          wr_is_mask_d = 1'b1;
          wr_addr_d    = addr_d;
          wr_data_d    = mask_q;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          unique case (op_q)
            OP_INSTALL: entry_valid_d[addr_q] = 1'b1;
            OP_DELETE:  entry_valid_d[addr_q] = 1'b0;
            default: begin
              entry_valid_d = '0;
              addr_d        = '0;
            end
          endcase
        end
      end

      S_RESP: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // NOTE: all state updates use non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_INSTALL;
      addr_q      <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_value_q <= '0;
      rsp_mask_q  <= '0;
      wr_en       <= 1'b0;
      wr_is_mask  <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      entry_valid <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      value_q     <= value_d;
      mask_q      <= mask_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_value_q <= rsp_value_d;
      rsp_mask_q  <= rsp_mask_d;
      wr_en       <= wr_en_d;
      wr_is_mask  <= wr_is_mask_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      entry_valid <= entry_valid_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_mask  = rsp_mask_q;

endmodule
